calc_ctrl: RTL and testbench

CALC_CTRL -- requirements
Module: calc_ctrl

---
 rtl/calc_ctrl.sv | 172 +++++++++++++++++
 tb/tb_calc_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_ctrl.sv
// Keypad calculator controller: digit entry, operator sequencing and one-cycle ALU execution.
// Optional operator chaining is enabled by defining CALC_CHAIN_EN.
module calc_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [19:0] alu_a,
    output logic [19:0] alu_b,
    output logic [1:0]  alu_op,
    input  logic [19:0] alu_res,
    output logic [19:0] disp,
    output logic        busy,
    output logic        result_valid,
    output logic        err
);

    typedef enum logic [2:0] {ENTER_A, OP_HELD, ENTER_B, EXEC, DONE} state_t;

    state_t      state, state_nx;
    logic [19:0] a_q, a_nx, b_q, b_nx, res_q, res_nx;
    logic [1:0]  op_q, op_nx;
    logic        err_q, err_nx, rv_q, rv_nx;
`ifdef CALC_CHAIN_EN
    logic [1:0]  pend_q, pend_nx;
    logic        chain_q, chain_nx;
`endif

    logic        is_dig, is_opk, is_eq, is_clr;
    logic [1:0]  key_op;
    logic [23:0] acc_a, acc_b;

    always_comb begin
        is_dig = key_valid && (key_code <= 4'd9);
        is_opk = key_valid && (key_code >= 4'd10) && (key_code <= 4'd13);
        is_eq  = key_valid && (key_code == 4'd14);
        is_clr = key_valid && (key_code == 4'd15);
        // Keys 10..13 map onto opcodes 0..3 by adding 2 modulo 4.
        key_op = key_code[1:0] + 2'd2;
        acc_a  = 24'(a_q) * 24'd10 + 24'(key_code);
        acc_b  = 24'(b_q) * 24'd10 + 24'(key_code);
    end

    always_comb begin
        state_nx = state;
        a_nx     = a_q;
        b_nx     = b_q;
        res_nx   = res_q;
        op_nx    = op_q;
        err_nx   = err_q;
        rv_nx    = 1'b0;
`ifdef CALC_CHAIN_EN
        pend_nx  = pend_q;
        chain_nx = chain_q;
`endif
        if (is_clr) begin
            state_nx = ENTER_A;
            a_nx     = '0;
            b_nx     = '0;
            res_nx   = '0;
            op_nx    = '0;
            err_nx   = 1'b0;
`ifdef CALC_CHAIN_EN
            pend_nx  = '0;
            chain_nx = 1'b0;
`endif
        end else begin
            case (state)
                ENTER_A: begin
                    if (is_dig) begin
                        if (acc_a > 24'hFFFFF) err_nx = 1'b1;
                        else                   a_nx   = acc_a[19:0];
                    end else if (is_opk) begin
                        op_nx    = key_op;
                        state_nx = OP_HELD;
                    end
                end
                OP_HELD: begin
                    if (is_dig) begin
                        b_nx     = 20'(key_code);
                        state_nx = ENTER_B;
                    end else if (is_opk) begin
                        op_nx = key_op;
                    end
                end
                ENTER_B: begin
                    if (is_dig) begin
                        if (acc_b > 24'hFFFFF) err_nx = 1'b1;
                        else                   b_nx   = acc_b[19:0];
                    end else if (is_eq) begin
                        state_nx = EXEC;
                    end
`ifdef CALC_CHAIN_EN
                    else if (is_opk) begin
                        pend_nx  = key_op;
                        chain_nx = 1'b1;
                        state_nx = EXEC;
                    end
`endif
                end
                EXEC: begin
                    res_nx   = alu_res;
                    rv_nx    = 1'b1;
                    state_nx = DONE;
`ifdef CALC_CHAIN_EN
                    if (chain_q) begin
                        a_nx     = alu_res;
                        op_nx    = pend_q;
                        chain_nx = 1'b0;
                        state_nx = OP_HELD;
                    end
`endif
                end
                DONE: begin
                    if (is_dig) begin
                        a_nx     = 20'(key_code);
                        state_nx = ENTER_A;
                    end else if (is_opk) begin
                        a_nx     = res_q;
                        op_nx    = key_op;
                        state_nx = OP_HELD;
                    end
                end
                default: state_nx = ENTER_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= '0;
            err_q   <= 1'b0;
            rv_q    <= 1'b0;
`ifdef CALC_CHAIN_EN
            pend_q  <= '0;
            chain_q <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            a_q     <= a_nx;
            b_q     <= b_nx;
            res_q   <= res_nx;
            op_q    <= op_nx;
            err_q   <= err_nx;
            rv_q    <= rv_nx;
`ifdef CALC_CHAIN_EN
            pend_q  <= pend_nx;
            chain_q <= chain_nx;
`endif
        end
    end

    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_op       = op_q;
    assign err          = err_q;
    assign result_valid = rv_q;
    assign busy         = (state == EXEC);

    always_comb begin
        case (state)
            ENTER_B, EXEC: disp = b_q;
            DONE:          disp = res_q;
            default:       disp = a_q;
        endcase
    end

endmodule

// File: tb/tb_calc_ctrl.sv
// Self-checking bench for calc_ctrl with a behavioural ALU and a result scoreboard.
module tb_calc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic [19:0] alu_a, alu_b, alu_res, disp;
    logic [1:0]  alu_op;
    logic        busy, result_valid, err;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [19:0] exp_q[$];

    localparam logic [3:0] K_ADD = 4'd10, K_SUB = 4'd11, K_MUL = 4'd12,
                           K_DIV = 4'd13, K_EQ = 4'd14, K_CLR = 4'd15;

    calc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
        .disp(disp), .busy(busy), .result_valid(result_valid), .err(err)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            2'b00:   alu_res = alu_a + alu_b;
            2'b01:   alu_res = alu_a - alu_b;
            2'b10:   alu_res = 20'(alu_a * alu_b);
            default: alu_res = (alu_b == 20'd0) ? 20'd0 : alu_a / alu_b;
        endcase
    end

    // Scoreboard: every result_valid pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            total_cnt++;
            if (exp_q.size() == 0)
                $display("FAIL sb_unexpected: result_valid pulse with disp=%0d, none expected", disp);
            else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                if (disp !== e) $display("FAIL sb_result: got %0d, expected %0d", disp, e);
                else pass_cnt++;
            end
        end
    end

    // Caller is at a negedge; the key is sampled at the next posedge.
    task automatic press(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic press_num(input int v);
        int d[$];
        do begin
            d.push_front(v % 10);
            v = v / 10;
        end while (v > 0);
        foreach (d[i]) press(4'(d[i]));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({alu_a, alu_b, alu_op, disp, busy, result_valid, err} !== 65'd0)
            $display("FAIL reset_outputs: a=%0d b=%0d op=%0d disp=%0d busy=%b rv=%b err=%b, all required 0",
                     alu_a, alu_b, alu_op, disp, busy, result_valid, err);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        press_num(123);
        total_cnt++;
        if (disp !== 20'd123) $display("FAIL add_entry_a: got %0d, expected 123", disp);
        else pass_cnt++;
        press(K_ADD);
        press_num(321);
        total_cnt++;
        if (disp !== 20'd321) $display("FAIL add_entry_b: got %0d, expected 321", disp);
        else pass_cnt++;
        press(K_EQ);
        exp_q.push_back(20'd444);
        total_cnt++;
        if (busy !== 1'b1 || alu_op !== 2'b00 || alu_a !== 20'd123 || alu_b !== 20'd321)
            $display("FAIL add_exec: busy=%b op=%0d a=%0d b=%0d, expected 1/0/123/321", busy, alu_op, alu_a, alu_b);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || result_valid !== 1'b1 || disp !== 20'd444)
            $display("FAIL add_result: busy=%b rv=%b disp=%0d, expected 0/1/444", busy, result_valid, disp);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (result_valid !== 1'b0 || disp !== 20'd444)
            $display("FAIL add_pulse_width: rv=%b disp=%0d, expected 0/444", result_valid, disp);
        else pass_cnt++;
    endtask

    task automatic test_ops();
        int          ta[3] = '{28, 36, 12};
        int          tb[3] = '{6, 17, 4};
        logic [3:0]  tk[3] = '{K_SUB, K_MUL, K_DIV};
        logic [1:0]  to[3] = '{2'b01, 2'b10, 2'b11};
        logic [19:0] te[3] = '{20'd22, 20'd612, 20'd3};
        for (int i = 0; i < 3; i++) begin
            press(K_CLR);
            press_num(ta[i]);
            press(tk[i]);
            press_num(tb[i]);
            press(K_EQ);
            exp_q.push_back(te[i]);
            total_cnt++;
            if (busy !== 1'b1 || alu_op !== to[i])
                $display("FAIL ops_exec_%0d: busy=%b op=%0d, expected 1/%0d", i, busy, alu_op, to[i]);
            else pass_cnt++;
            @(negedge clk);
            total_cnt++;
            if (disp !== te[i]) $display("FAIL ops_result_%0d: got %0d, expected %0d", i, disp, te[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_overflow();
        press(K_CLR);
        press_num(104857);
        total_cnt++;
        if (err !== 1'b0 || disp !== 20'd104857)
            $display("FAIL ovf_before: err=%b disp=%0d, expected 0/104857", err, disp);
        else pass_cnt++;
        press(4'd6);
        total_cnt++;
        if (err !== 1'b1 || disp !== 20'd104857)
            $display("FAIL ovf_digit: err=%b disp=%0d, expected 1/104857", err, disp);
        else pass_cnt++;
        press(4'd1);
        total_cnt++;
        if (err !== 1'b1) $display("FAIL ovf_sticky: err=%b, expected 1", err);
        else pass_cnt++;
        press(K_CLR);
        total_cnt++;
        if (err !== 1'b0 || disp !== 20'd0)
            $display("FAIL ovf_clear: err=%b disp=%0d, expected 0/0", err, disp);
        else pass_cnt++;
    endtask

    task automatic test_chain();
        logic [19:0] fin;
        press(K_CLR);
        press(4'd5);
        press(K_ADD);
        press(4'd3);
        press(K_MUL);
`ifdef CALC_CHAIN_EN
        exp_q.push_back(20'd8);
        fin = 20'd16;
        @(negedge clk);
`else
        fin = 20'd37;
`endif
        press(4'd2);
        press(K_EQ);
        exp_q.push_back(fin);
        @(negedge clk);
        total_cnt++;
        if (disp !== fin) $display("FAIL chain_result: got %0d, expected %0d", disp, fin);
        else pass_cnt++;
    endtask

    task automatic test_exec_abort();
        // Digit strobed during EXEC must be ignored.
        press(K_CLR);
        press(4'd7); press(K_ADD); press(4'd8); press(K_EQ);
        exp_q.push_back(20'd15);
        press(4'd9);
        @(negedge clk);
        total_cnt++;
        if (disp !== 20'd15) $display("FAIL exec_key_ignored: disp=%0d, expected 15", disp);
        else pass_cnt++;
        // CLEAR during EXEC wins; no pulse.
        press(K_CLR);
        press(4'd7); press(K_ADD); press(4'd8); press(K_EQ);
        press(K_CLR);
        total_cnt++;
        if (disp !== 20'd0 || result_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL exec_clear: disp=%0d rv=%b busy=%b, expected 0/0/0", disp, result_valid, busy);
        else pass_cnt++;
        // Reset during EXEC.
        press(4'd7); press(K_ADD); press(4'd8); press(K_EQ);
        rst_n = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({alu_a, alu_b, alu_op, disp, busy, result_valid, err} !== 65'd0)
            $display("FAIL exec_reset: a=%0d b=%0d op=%0d disp=%0d busy=%b rv=%b err=%b, all required 0",
                     alu_a, alu_b, alu_op, disp, busy, result_valid, err);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        press(4'd4); press(4'd5); press(K_EQ);
        total_cnt++;
        if (disp !== 20'd45 || busy !== 1'b0)
            $display("FAIL exec_reset_state: disp=%0d busy=%b, expected 45/0", disp, busy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        press(K_CLR);
        press_num(123); press(K_ADD); press_num(321); press(K_EQ);
        exp_q.push_back(20'd444);
        @(negedge clk);
        press(K_ADD);
        total_cnt++;
        if (disp !== 20'd444 || alu_a !== 20'd444)
            $display("FAIL b2b_reuse: disp=%0d a=%0d, expected 444/444", disp, alu_a);
        else pass_cnt++;
        press(4'd6); press(K_EQ);
        exp_q.push_back(20'd450);
        @(negedge clk);
        total_cnt++;
        if (disp !== 20'd450) $display("FAIL b2b_result: got %0d, expected 450", disp);
        else pass_cnt++;
        press(4'd9);
        total_cnt++;
        if (disp !== 20'd9) $display("FAIL b2b_new_digit: got %0d, expected 9", disp);
        else pass_cnt++;
        press(K_EQ);
        total_cnt++;
        if (busy !== 1'b0 || disp !== 20'd9)
            $display("FAIL b2b_enter_a: busy=%b disp=%0d, expected 0/9", busy, disp);
        else pass_cnt++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_add();
        test_ops();
        test_overflow();
        test_chain();
        test_exec_abort();
        test_back_to_back();
        repeat (3) @(negedge clk);
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL sb_leftover: %0d results never produced, expected 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
